registered_logic_array: RTL and testbench

- Parametrised successor to the fixed three-gate registered logic block.
- NUM_CH independent channels, each WIDTH bits wide. Each channel applies a run-time selectable bitwise operation to operands A and B.
- Results pass through a 2-stage valid/ready pipeline with backpressure.
- Adds per-channel sticky change detection on delivered results and a saturating count of delivered results.
- Sits between operand-producing logic and any registered consumer that can stall.

---
 rtl/logic_array_pkg.sv | 44 ++++
 rtl/logic_op_lane.sv | 24 ++
 rtl/registered_logic_array.sv | 165 ++++++++++++++++
 tb/tb_registered_logic_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_array_pkg.sv
// -----------------------------------------------------------------------------
// logic_array_pkg
//   Shared definitions for registered_logic_array:
//     OP_W           width of a per-channel op select
//     OP_NOR..OP_PASSA  op select encodings
//     lane_bit()     single-bit result of an op; lanes apply it bitwise
// -----------------------------------------------------------------------------
package logic_array_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOR   = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR    = 3'd2;
    localparam logic [OP_W-1:0] OP_AND   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

    // Every op is bitwise, so one bit fully describes it; this keeps the
    // function independent of the lane width.
    function automatic logic lane_bit(
        input logic            a,
        input logic            b,
        input logic [OP_W-1:0] op
    );
        logic y;
        y = 1'b0;
        case (op)
            OP_NOR:   y = ~(a | b);
            OP_NAND:  y = ~(a & b);
            OP_OR:    y = a | b;
            OP_AND:   y = a & b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_op_lane.sv
// -----------------------------------------------------------------------------
// logic_op_lane
//   Purely combinational WIDTH-bit lane: y = op(a, b), applied bitwise.
//   Ports:
//     a, b  [WIDTH-1:0]  operands
//     op    [OP_W-1:0]   op select (see logic_array_pkg)
//     y     [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module logic_op_lane
    import logic_array_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = lane_bit(a[gi], b[gi], op);
    end

endmodule

// File: rtl/registered_logic_array.sv
// -----------------------------------------------------------------------------
// registered_logic_array
//   NUM_CH independent WIDTH-bit channels, each applying a run-time selected
//   bitwise op to A and B. Results travel through a two-stage valid/ready
//   pipeline (stage 1 holds operands, stage 2 holds results) with full
//   backpressure. Delivered results feed per-channel sticky change flags and
//   a saturating handshake counter.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand beat handshake
//     in_a, in_b            operands, channel c at [c*WIDTH +: WIDTH]
//     in_op                 op selects, channel c at [c*OP_W +: OP_W]
//     out_valid / out_ready result beat handshake
//     out_data              results, packed like in_a
//     chg_flag              sticky per-channel "delivered result changed"
//     chg_clr               synchronous clear of chg_flag (a set wins)
//     result_cnt            saturating count of output handshakes
// -----------------------------------------------------------------------------
module registered_logic_array
    import logic_array_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*WIDTH-1:0]  in_a,
    input  logic [NUM_CH*WIDTH-1:0]  in_b,
    input  logic [NUM_CH*OP_W-1:0]   in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0]        chg_flag,
    input  logic                     chg_clr,
    output logic [CNT_W-1:0]         result_cnt
);

    localparam int DW = NUM_CH * WIDTH;

    // Stage 1: registered operands
    logic                   s1_valid_q, s1_valid_d;
    logic [DW-1:0]          s1_a_q, s1_a_d;
    logic [DW-1:0]          s1_b_q, s1_b_d;
    logic [NUM_CH*OP_W-1:0] s1_op_q, s1_op_d;

    // Stage 2: registered results
    logic                   s2_valid_q, s2_valid_d;
    logic [DW-1:0]          s2_data_q, s2_data_d;

    // Delivered-result tracking
    logic [DW-1:0]          last_q, last_d;
    logic [NUM_CH-1:0]      chg_q, chg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [DW-1:0]          s1_result;
    logic                   adv2;
    logic                   in_hs;
    logic                   out_hs;

    // One combinational lane per channel, fed from stage 1.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        logic_op_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .a  (s1_a_q[gi*WIDTH +: WIDTH]),
            .b  (s1_b_q[gi*WIDTH +: WIDTH]),
            .op (s1_op_q[gi*OP_W +: OP_W]),
            .y  (s1_result[gi*WIDTH +: WIDTH])
        );
    end

    // Handshake. in_ready looks through to out_ready so a full pipe can still
    // take a beat in the same cycle it delivers one (no skid buffer).
    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || adv2;
        in_hs    = in_valid && in_ready;
        out_hs   = s2_valid_q && out_ready;
    end

    // Pipeline next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_hs) begin
            s1_a_d  = in_a;
            s1_b_d  = in_b;
            s1_op_d = in_op;
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            // Only overwrite the result on a real beat so out_data does not
            // wander while the output is idle.
            if (s1_valid_q) begin
                s2_data_d = s1_result;
            end
        end
    end

    // Change flags, last-delivered values and result counter
    always_comb begin
        last_d = last_q;
        chg_d  = chg_q;
        cnt_d  = cnt_q;

        for (int c = 0; c < NUM_CH; c++) begin
            // Clear first so that a same-cycle set overrides it.
            if (chg_clr) begin
                chg_d[c] = 1'b0;
            end
            if (out_hs) begin
                if (s2_data_q[c*WIDTH +: WIDTH] != last_q[c*WIDTH +: WIDTH]) begin
                    chg_d[c] = 1'b1;
                end
                last_d[c*WIDTH +: WIDTH] = s2_data_q[c*WIDTH +: WIDTH];
            end
        end

        if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            last_q     <= '0;
            chg_q      <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            last_q     <= last_d;
            chg_q      <= chg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign chg_flag   = chg_q;
    assign result_cnt = cnt_q;

endmodule

// File: tb/tb_registered_logic_array.sv
// -----------------------------------------------------------------------------
// tb_registered_logic_array
//   Two instances share all stimulus: the default build (CNT_W=16) and a
//   narrow-counter build (CNT_W=3) that exercises counter saturation.
//   A transaction-level model (queue of expected results, flag/count state)
//   is checked on every falling edge; directed steps add literal checks.
// -----------------------------------------------------------------------------
module tb_registered_logic_array;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int DW = N * W;
    localparam logic [N*3-1:0] ALL_PASS = {3'd7, 3'd7, 3'd7};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic [DW-1:0] in_a, in_b;
    logic [N*3-1:0] in_op;
    logic          out_ready;
    logic          chg_clr;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [N-1:0]  chg_flag;
    logic [15:0]   result_cnt;

    logic          in_ready_s, out_valid_s;
    logic [DW-1:0] out_data_s;
    logic [N-1:0]  chg_flag_s;
    logic [2:0]    result_cnt_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    registered_logic_array #(.WIDTH(W), .NUM_CH(N), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .chg_flag(chg_flag), .chg_clr(chg_clr), .result_cnt(result_cnt)
    );

    registered_logic_array #(.WIDTH(W), .NUM_CH(N), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .chg_flag(chg_flag_s), .chg_clr(chg_clr), .result_cnt(result_cnt_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Result of a beat straight from the op table.
    function automatic logic [DW-1:0] model_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [N*3-1:0] op);
        logic [DW-1:0] r;
        logic [W-1:0]  x, y;
        r = '0;
        for (int c = 0; c < N; c++) begin
            x = a[c*W +: W];
            y = b[c*W +: W];
            case (op[c*3 +: 3])
                3'd0: r[c*W +: W] = ~(x | y);
                3'd1: r[c*W +: W] = ~(x & y);
                3'd2: r[c*W +: W] = x | y;
                3'd3: r[c*W +: W] = x & y;
                3'd4: r[c*W +: W] = x ^ y;
                3'd5: r[c*W +: W] = ~(x ^ y);
                3'd6: r[c*W +: W] = ~x;
                default: r[c*W +: W] = x;
            endcase
        end
        return r;
    endfunction

    // ---------------- transaction model + per-cycle compare ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_last;
    logic [N-1:0]  m_chg;
    int            m_cnt;

    always @(negedge clk) begin
        logic [N-1:0]  nchg;
        logic [DW-1:0] d;
        logic          m_ready;
        if (!rst_n) begin
            exp_q.delete();
            m_last = '0;
            m_chg  = '0;
            m_cnt  = 0;
        end else begin
            // Pipe holds at most two beats; with both held it only takes a
            // new beat if the consumer takes one.
            m_ready = (exp_q.size() < 2) || out_ready;
            chk("in_ready", in_ready, m_ready);
            chk("sat_in_ready", in_ready_s, m_ready);
            if (exp_q.size() == 0) begin
                chk("out_valid_empty", out_valid, 0);
            end else if (out_valid) begin
                chk("out_data", out_data, exp_q[0]);
            end
            if (out_valid_s && exp_q.size() != 0) chk("sat_out_data", out_data_s, exp_q[0]);
            chk("chg_flag", chg_flag, m_chg);
            chk("sat_chg_flag", chg_flag_s, m_chg);
            chk("result_cnt", result_cnt, lim(m_cnt, 65535));
            chk("sat_result_cnt", result_cnt_s, lim(m_cnt, 7));

            nchg = chg_clr ? '0 : m_chg;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                d = exp_q.pop_front();
                for (int c = 0; c < N; c++)
                    if (d[c*W +: W] != m_last[c*W +: W]) nchg[c] = 1'b1;
                m_last = d;
                m_cnt++;
            end
            m_chg = nchg;
            if (in_valid && m_ready) exp_q.push_back(model_op(in_a, in_b, in_op));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [N*3-1:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    endtask

    // Single PASS-A beat into an empty pipe with out_ready high; returns
    // just after the delivering edge. Optionally pulses chg_clr on that edge.
    task automatic send(input logic [DW-1:0] a, input logic clr_at_delivery);
        set_beat(a, '0, ALL_PASS);
        step();                       // accepted
        in_valid = 1'b0;
        step();                       // result visible
        chg_clr = clr_at_delivery;
        step();                       // delivered
        chg_clr = 1'b0;
        $display("send a=%h clr=%0b -> chg_flag=%b cnt=%0d", a, clr_at_delivery, chg_flag, result_cnt);
    endtask

    initial begin
        logic [DW-1:0] held;
        in_valid = 0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1; chg_clr = 0;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_chg_flag", chg_flag, 0);
        chk("rst_result_cnt", result_cnt, 0);
        #20 rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // Single beat: {NOR,NAND,OR}
        set_beat(24'h0FF0AA, 24'h000F55, {3'd0, 3'd1, 3'd2});
        step();
        chk("single_lat1_valid", out_valid, 0);
        in_valid = 0;
        step();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 24'hF0FFFF);
        step();
        chk("single_chg", chg_flag, 3'b111);
        chk("single_cnt", result_cnt, 1);
        $display("single beat -> data=%h chg=%b cnt=%0d", 24'hF0FFFF, chg_flag, result_cnt);

        // Streaming: 10 back-to-back beats covering every op
        for (int k = 0; k < 14; k++) begin
            if (k < 10) begin
                set_beat({8'(k), 8'(k * 3 + 1), 8'(k * 37)},
                         {8'(8'hA5 ^ k), 8'(k * 5), 8'(8'h3C + k)},
                         {3'(k), 3'(k + 1), 3'(k + 2)});
                chk("stream_in_ready", in_ready, 1);
            end else begin
                in_valid = 0;
            end
            step();
            chk("stream_out_valid", out_valid, (k >= 1) && (k <= 10));
            $display("stream k=%0d out_valid=%0b out_data=%h", k, out_valid, out_data);
        end
        chk("stream_cnt", result_cnt, 11);
        chk("sat_cnt_7", result_cnt_s, 7);

        // Backpressure
        out_ready = 0;
        set_beat(24'h123456, 24'h0F0F0F, {3'd4, 3'd4, 3'd4});
        step();
        chk("bp_ready_one_full", in_ready, 1);
        set_beat(24'h111111, 24'h222222, {3'd2, 3'd3, 3'd5});
        step();
        set_beat(24'h808080, 24'h010101, {3'd1, 3'd0, 3'd6});
        held = out_data;
        chk("bp_head_literal", held, 24'h1D3B59);
        chk("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", out_data, held);
            step();
            $display("stall %0d out_data=%h in_ready=%0b", i, out_data, in_ready);
        end
        out_ready = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 8 && out_valid; i++) step();
        chk("bp_drained", out_valid, 0);
        chk("bp_cnt", result_cnt, 14);
        chk("sat_cnt_hold", result_cnt_s, 7);

        // Change flags and clear
        send(24'hA1B2C3, 0);
        send(24'hA1B2C3, 0);
        chg_clr = 1; step(); chg_clr = 0;
        chk("clr_flags", chg_flag, 3'b000);
        send(24'hA1B2C3, 0);
        chk("same_flags", chg_flag, 3'b000);
        send(24'hA1FFC3, 0);
        chk("ch1_flag", chg_flag, 3'b010);
        send(24'hA1FFC4, 1);
        chk("set_beats_clr", chg_flag, 3'b001);

        // Async reset with two beats in flight
        set_beat(24'h445566, 24'h778899, {3'd3, 3'd4, 3'd5});
        step();
        set_beat(24'hDEADBE, 24'h010203, {3'd2, 3'd1, 3'd0});
        step();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_chg", chg_flag, 0);
        chk("arst_cnt", result_cnt, 0);
        chk("arst_sat_cnt", result_cnt_s, 0);
        step();
        #2 rst_n = 1;
        step();
        chk("arst_no_out1", out_valid, 0);
        step();
        chk("arst_no_out2", out_valid, 0);
        send(24'h00005A, 0);
        chk("arst_first_vs_zero", chg_flag, 3'b001);
        chk("arst_cnt_after", result_cnt, 1);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
